mcseq: RTL

MCSEQ -- requirements
Module: mcseq

---
 rtl/mcseq.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mcseq.sv
// ---------------------------------------------------------------------------
// mcseq -- multi-cycle RISC-V style control sequencer.
//
// A Moore FSM that walks each instruction through fetch, decode and
// execute/memory/write-back steps. It drives the datapath multiplexer
// selects and the write strobes for a shared-memory multi-cycle CPU.
//
// Optional feature (compile-time macro MCSEQ_INSTRET_EN):
//   adds a 32-bit retired-instruction counter on output port instret.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   op         in   7-bit opcode of the latched instruction register
//   iszero     in   branch-taken condition from the datapath comparator
//   mem_ready  in   memory completes the current request this cycle
//   mem_req    out  memory request
//   mem_we     out  memory write enable
//   adrsrc     out  memory address select (0 = PC, 1 = ALUOut)
//   irwrite    out  instruction-register write strobe
//   pcwrite    out  PC write strobe
//   regwrite   out  register-file write strobe
//   alusrc_a   out  ALU A select (0 = PC, 1 = oldPC, 2 = rs1 latch)
//   alusrc_b   out  ALU B select (0 = rs2 latch, 1 = imm, 2 = constant 4)
//   aluop      out  ALU op (0 = add, 1 = sub/compare, 2 = decode funct)
//   resultsrc  out  result select (0 = ALUOut, 1 = mem data, 2 = ALU, 3 = imm)
//   illegal    out  sticky unsupported-opcode flag
//   state      out  current state encoding
//   instret    out  retired-instruction count (MCSEQ_INSTRET_EN only)
// ---------------------------------------------------------------------------
module mcseq (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic        iszero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adrsrc,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        regwrite,
  output logic [1:0]  alusrc_a,
  output logic [1:0]  alusrc_b,
  output logic [1:0]  aluop,
  output logic [1:0]  resultsrc,
  output logic        illegal,
  output logic [3:0]  state
`ifdef MCSEQ_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Code 14 is deliberately left out; the next-state default recovers it.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_LINK     = 4'd10,
    S_JUMP     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  // Per-state control word. fetch/branch mark the two states whose PC/IR
  // strobes are qualified by a live input rather than fixed by the state.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adrsrc;
    logic       fetch;
    logic       branch;
    logic       pcwrite;
    logic       regwrite;
    logic [1:0] alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
  } ctrl_t;

  state_t state_q;
  state_t nxt;
  ctrl_t  ctrl_q;
  logic   illegal_q;

  function automatic state_t next_state(input state_t s, input logic [6:0] opc,
                                        input logic rdy);
    state_t n;
    // NOTE: default assignment first so every path assigns n; a path that
    // leaves it unassigned would infer a latch if this logic were in always_comb.
    n = S_FETCH;
    case (s)
      S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opc)
          OP_LOAD, OP_STORE: n = S_MEMADR;
          OP_RTYPE:          n = S_EXECR;
          OP_ITYPE:          n = S_EXECI;
          OP_BRANCH:         n = S_BRANCH;
          OP_JAL, OP_JALR:   n = S_LINK;
          OP_LUI:            n = S_LUI;
          OP_AUIPC:          n = S_AUIPC;
          default:           n = S_TRAP;
        endcase
      end
      S_MEMADR:   n = (opc == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  n = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    n = S_FETCH;
      S_MEMWRITE: n = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    n = S_ALUWB;
      S_EXECI:    n = S_ALUWB;
      S_ALUWB:    n = S_FETCH;
      S_BRANCH:   n = S_FETCH;
      S_LINK:     n = S_JUMP;
      S_JUMP:     n = S_FETCH;
      S_LUI:      n = S_FETCH;
      S_AUIPC:    n = S_ALUWB;
      S_TRAP:     n = S_TRAP;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t s, input logic [6:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch     = 1'b1;
        c.alusrc_b  = 2'd2;
        c.resultsrc = 2'd2;
      end
      S_MEMADR: begin
        c.alusrc_a = 2'd2;
        c.alusrc_b = 2'd1;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite  = 1'b1;
        c.resultsrc = 2'd1;
      end
      S_MEMWRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adrsrc  = 1'b1;
      end
      S_EXECR: begin
        c.alusrc_a = 2'd2;
        c.aluop    = 2'd2;
      end
      S_EXECI: begin
        c.alusrc_a = 2'd2;
        c.alusrc_b = 2'd1;
        c.aluop    = 2'd2;
      end
      S_ALUWB: c.regwrite = 1'b1;
      S_BRANCH: begin
        c.branch   = 1'b1;
        c.alusrc_a = 2'd2;
        c.aluop    = 2'd1;
      end
      S_LINK: begin
        c.alusrc_a  = 2'd1;
        c.alusrc_b  = 2'd2;
        c.resultsrc = 2'd2;
        c.regwrite  = 1'b1;
      end
      S_JUMP: begin
        // JAL targets oldPC+imm; JALR uses the rs1 value latched in DECODE,
        // so the LINK write to rd cannot corrupt it when rd == rs1.
        c.alusrc_a  = (opc == OP_JAL) ? 2'd1 : 2'd2;
        c.alusrc_b  = 2'd1;
        c.resultsrc = 2'd2;
        c.pcwrite   = 1'b1;
      end
      S_LUI: begin
        c.regwrite  = 1'b1;
        c.resultsrc = 2'd3;
      end
      S_AUIPC: begin
        c.alusrc_a = 2'd1;
        c.alusrc_b = 2'd1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign nxt = next_state(state_q, op, mem_ready);

  // The control word is registered together with the state it belongs to,
  // so the selects come straight off flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // pre-edge values regardless of statement order.
      state_q   <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH, 7'd0);
      illegal_q <= 1'b0;
`ifdef MCSEQ_INSTRET_EN
      instret   <= 32'd0;
`endif
    end else begin
      state_q   <= nxt;
      ctrl_q    <= decode_ctrl(nxt, op);
      illegal_q <= illegal_q | (nxt == S_TRAP);
`ifdef MCSEQ_INSTRET_EN
      // Counts completed instructions; FETCH stalls do not retire anything.
      // Wraps naturally at 32 bits.
      if ((state_q != S_FETCH) && (nxt == S_FETCH))
        instret <= instret + 32'd1;
`endif
    end
  end

  // Strobes are masked by reset so nothing fires while reset is held, even
  // though the registered control word already shows the FETCH pattern.
  assign mem_req   = ctrl_q.mem_req  & ~reset;
  assign mem_we    = ctrl_q.mem_we   & ~reset;
  assign regwrite  = ctrl_q.regwrite & ~reset;
  assign irwrite   = ctrl_q.fetch & mem_ready & ~reset;
  assign pcwrite   = ((ctrl_q.fetch & mem_ready) | (ctrl_q.branch & iszero) |
                      ctrl_q.pcwrite) & ~reset;
  assign adrsrc    = ctrl_q.adrsrc;
  assign alusrc_a  = ctrl_q.alusrc_a;
  assign alusrc_b  = ctrl_q.alusrc_b;
  assign aluop     = ctrl_q.aluop;
  assign resultsrc = ctrl_q.resultsrc;
  assign illegal   = illegal_q;
  assign state     = state_q;

endmodule
